// File: rtl/nfc_pkg.sv
// Shared NAND flash controller command format and sizing constants.
// Purely declarative; no latency or flow control of its own.
package nfc_pkg;

    localparam int CMD_W         = 33;
    localparam int MEM_WORDS     = 128;
    localparam int DEFAULT_DEPTH = 4;

    localparam int CMD_RD_BIT = 32;
    localparam int FADDR_MSB  = 31;
    localparam int FADDR_LSB  = 14;
    localparam int MADDR_MSB  = 13;
    localparam int MADDR_LSB  = 7;
    localparam int LEN_MSB    = 6;
    localparam int LEN_LSB    = 0;

    typedef struct packed {
        logic        rd;
        logic [17:0] faddr;
        logic [6:0]  maddr;
        logic [6:0]  len;
    } cmd_t;

    // A transfer must end at or before the last memory word; sum fits in 8 bits.
    function automatic logic range_bad(logic [6:0] maddr, logic [6:0] len);
        logic [7:0] sum;
        sum = {1'b0, maddr} + {1'b0, len};
        return sum > 8'(MEM_WORDS);
    endfunction

endpackage

// File: rtl/nfc_cmd_queue_if.sv
// Host-side command push, NFC-side head/done handshake and status counters.
// Wiring only; slave is the queue, master is the host/NFC environment.
interface nfc_cmd_queue_if;
    import nfc_pkg::*;

    logic             in_valid;
    logic [CMD_W-1:0] in_cmd;
    logic             in_ready;
    logic             flush;
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             done;
    logic             err_range;
    logic [7:0]       drop_cnt;
    logic [7:0]       issue_cnt;

    modport slave (
        input  in_valid, in_cmd, flush, done,
        output in_ready, cmd, cmd_valid, err_range, drop_cnt, issue_cnt
    );

    modport master (
        output in_valid, in_cmd, flush, done,
        input  in_ready, cmd, cmd_valid, err_range, drop_cnt, issue_cnt
    );

endinterface

// File: rtl/nfc_cmd_fifo.sv
// Circular command store with occupancy count; head valid one cycle after push (no bypass).
// Push ignored when full, pop ignored when empty, flush clears and overrides both.
module nfc_cmd_fifo
    import nfc_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = CMD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign push_ok  = push & ~full & ~flush;
    assign pop_ok   = pop & ~empty & ~flush;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload needs no reset: head_dat is forced to zero while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/nfc_cmd_queue.sv
// Validates host commands, queues the good ones for the NFC, counts drops and issues.
// Head visible one cycle after push; in_ready = not-full; pops on done while valid.
module nfc_cmd_queue
    import nfc_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    nfc_cmd_queue_if.slave bus
);

    logic       full, empty;
    logic       accept, len_zero, mem_oob, enq, pop;
    logic       err_range_q, err_range_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] issue_cnt_q, issue_cnt_d;

    // Flush swallows any same-cycle push, so a bad command under flush is not counted.
    assign accept   = bus.in_valid & ~full & ~bus.flush;
    assign len_zero = (bus.in_cmd[LEN_MSB:LEN_LSB] == '0);
    assign mem_oob  = range_bad(bus.in_cmd[MADDR_MSB:MADDR_LSB], bus.in_cmd[LEN_MSB:LEN_LSB]);
    assign enq      = accept & ~len_zero & ~mem_oob;
    assign pop      = bus.done & ~empty & ~bus.flush;

    nfc_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (enq),
        .push_dat (bus.in_cmd),
        .pop      (pop),
        .flush    (bus.flush),
        .head_dat (bus.cmd),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        err_range_d = err_range_q;
        drop_cnt_d  = drop_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (accept && (len_zero || mem_oob)) begin
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
            if (mem_oob) begin
                err_range_d = 1'b1;
            end
        end
        if (pop) begin
            issue_cnt_d = issue_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_range_q <= 1'b0;
            drop_cnt_q  <= '0;
            issue_cnt_q <= '0;
        end else begin
            err_range_q <= err_range_d;
            drop_cnt_q  <= drop_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.cmd_valid = ~empty;
    assign bus.err_range = err_range_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: doc/nfc_cmd_queue.md
NFC_CMD_QUEUE -- requirements
Module: nfc_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  host offers in_cmd this cycle.
REQ-005 SHALL have port in_cmd  input  33  command: [32]=1 read flash->memory, 0 write memory->flash; [31:14] flash address; [13:7] memory address; [6:0] length.
REQ-006 SHALL have port in_ready  output  1  queue can accept; equals not-full.
REQ-007 SHALL have port flush  input  1  discard all queued entries.
REQ-008 SHALL have port cmd  output  33  head entry, driven to NFC cmd.
REQ-009 SHALL have port cmd_valid  output  1  head entry present (queue non-empty).
REQ-010 SHALL have port done  input  1  from NFC; level, high while NFC idle and able to latch cmd.
REQ-011 SHALL have port err_range  output  1  sticky: a command was rejected for memory range.
REQ-012 SHALL have port drop_cnt  output  8  count of rejected or zero-length commands, saturating at 255.
REQ-013 SHALL have port issue_cnt  output  8  count of commands handed to NFC, wrapping modulo 256.

Function
REQ-014 SHALL accept a push when in_valid=1 and in_ready=1 on a rising edge.
REQ-015 SHALL drop an accepted command with length 0 (no enqueue, drop_cnt+1).
REQ-016 SHALL drop an accepted command with memory address + length > 128, computed 8-bit unsigned (no enqueue, drop_cnt+1, err_range<=1).
REQ-017 SHALL enqueue every other accepted command in arrival order; visible on cmd/cmd_valid the cycle after the push edge (no bypass).
REQ-018 SHALL pop the head on a rising edge where done=1 and cmd_valid=1, incrementing issue_cnt.
REQ-019 SHALL hold cmd stable while cmd_valid=1 and no pop occurs.
REQ-020 SHALL drive cmd to all zeros when cmd_valid=0.
REQ-021 SHALL allow push and pop on the same edge; occupancy unchanged; when full, in_ready stays 0 that cycle (no push-through-full).
REQ-022 SHALL on flush=1 empty the queue on that edge; a same-cycle push and pop are both ignored; counters and err_range are unaffected.
REQ-023 SHALL wrap read/write pointers modulo DEPTH, tracking occupancy with a DEPTH+1-state count so full and empty are distinct.
REQ-024 SHALL never pop when empty or push when full, whatever done/in_valid are.

Reset
REQ-025 SHALL on rst=1 clear the queue: cmd_valid=0, cmd=0, in_ready=1, err_range=0, drop_cnt=0, issue_cnt=0.
REQ-026 SHALL give rst priority over flush, push and pop in the same cycle, including mid-stream with entries queued.

Structure
REQ-027 SHALL take CMD_W=33, field bit positions, MEM_WORDS=128 and the default depth from shared package nfc_pkg.
REQ-028 SHALL implement storage and pointers in one sub-module nfc_cmd_fifo (push, pop, flush, full, empty); validation and counters stay in nfc_cmd_queue.

Verification
REQ-029 SHALL cover: reset, push 0x0_0000_0102 (write, faddr 0, maddr 2, len 2) with done=1 -> cmd_valid rises next cycle, pops the following edge, issue_cnt=1.
REQ-030 SHALL cover: done=0, push 5 valid commands with DEPTH=4 -> in_ready=0 after the fourth; fifth held by host until one done pop; issue order matches push order.
REQ-031 SHALL cover: push maddr=0x7F len=2 -> dropped, err_range=1, drop_cnt=1, cmd_valid stays 0; push len=0 -> drop_cnt=2, err_range still 1.
REQ-032 SHALL cover: queue holding 1 entry, push and done same edge -> occupancy stays 1, new entry becomes head.
REQ-033 SHALL cover: 3 entries queued, flush=1 with in_valid=1 and done=1 -> next cycle cmd_valid=0, cmd=0, issue_cnt unchanged.
REQ-034 SHALL cover: rst asserted with 2 entries queued and done=1 -> all outputs at reset values next cycle; 300 rejected pushes -> drop_cnt saturates at 255.
